fp_div_unit: RTL and testbench
==============================

// Module: fp_div_unit
// PURPOSE
//  Iterative single-precision (RV32F FDIV.S) divider beside fp_alu in the FP datapath.
//  Takes operands from the FP register-file read ports (fp_RD1 / fp_RD2) and returns the
//  quotient and fflags to the FP writeback mux.
//  busy stalls PC/control until done, so FDIV.S retires as a multi-cycle instruction.
// PARAMETERS
//  EXP_W   8   exponent width (only 8 is verified)
//  FRAC_W  23  stored fraction width (only 23 is verified)
// PORTS
//  clk     in   1   clock; everything on rising edge
//  reset   in   1   asynchronous, active-low reset
//  start   in   1   launch a divide; sampled only in IDLE
//  abort   in   1   synchronous cancel (pipeline flush/trap)
//  a       in   32  dividend, IEEE-754 binary32
//  b       in   32  divisor, IEEE-754 binary32
//  busy    out  1   high whenever state != IDLE
//  done    out  1   single-cycle pulse: result/fflags valid
//  result  out  32  quotient; held until next accepted start
//  fflags  out  5   {NV,DZ,OF,UF,NX}; held with result
// BEHAVIOUR
//  Reset (reset=0, async): state=IDLE; busy=0; done=0; result=32'h0; fflags=5'h0;
//    all internal registers cleared.
//  FSM: IDLE -> UNPACK -> (DIV -> ROUND | special) -> DONE -> IDLE.
//   - IDLE:   start=1 latches a/b into operand registers; next state UNPACK.
//   - UNPACK: flush subnormal inputs to signed zero. Classify; special -> DONE
//             with preset result. Else ma/mb = {1,frac} (24b); if ma<mb: ma<<=1, adj=1.
//             exp = ea-eb+127-adj (10b signed); sign = sa^sb.
//   - DIV:    restoring divide, 1 quotient bit/cycle, 25 cycles: 24 significand bits
//             + 1 round bit; sticky = (remainder != 0).
//   - ROUND:  RNE only. inc = R & (S | q[0]). Mantissa carry-out -> mant=1.0, exp+1.
//             exp>=255 -> signed inf, OF|NX.
//             exp<=0 -> signed zero (flush), UF|NX.
//             Otherwise NX = R|S.
//   - DONE:   done=1 for exactly this cycle; result/fflags registered here; next IDLE.
//  Latency (start sampled at edge ending cycle 0):
//   - normal: DIV spans cycles 2..26, ROUND is cycle 27, done at cycle 28.
//   - special: done at cycle 2.
//  Specials (priority top-down):
//   - either NaN -> 7FC00000; NV only if an input is sNaN.
//   - 0/0 or inf/inf -> 7FC00000, NV.
//   - inf/x -> signed inf, no flags.   x/0 (x finite, !=0) -> signed inf, DZ.
//   - 0/x or x/inf -> signed zero, no flags.
//  Boundaries:
//   - start while busy is ignored (no re-latch, no queueing).
//   - start in the same cycle as done has no effect; start is re-sampled once in IDLE.
//   - abort=1 in any non-IDLE state -> IDLE next edge; no done; result/fflags keep old values.
//   - abort and start in IDLE: abort wins, nothing launched.
//   - reset low mid-operation -> immediate IDLE, outputs at reset values, no done.
//   - a/b may change after start; only latched copies are used.
// TESTING
//  1. a=40C00000 (6.0), b=40000000 -> done at cycle 28; result=40400000; fflags=00.
//  2. a=3F800000, b=40400000 (1/3) -> result=3EAAAAAB; fflags=01 (NX).
//  3. a=3F800000, b=00000000 -> done at cycle 2; result=7F800000; fflags=08 (DZ).
//  4. a=00000000, b=80000000 -> result=7FC00000, fflags=10 (NV);
//     a=7F800001 (sNaN) -> 7FC00000, NV.
//  5. a=7F000000, b=00800000 -> result=7F800000, fflags=05 (OF|NX);
//     a=00800000, b=7F000000 -> result=00000000, fflags=03 (UF|NX).
//  6. start, then start again at cycle 5, abort at cycle 10, reset low at cycle 3 of a
//     second run -> no done, busy=0 the cycle after, prior result intact until reset.

Source files
------------

// File: rtl/fp_div_if.sv
// Handshake and operand/result bundle for the iterative FDIV.S unit.
// The master side launches divides; the slave side answers with busy/done/result/fflags.
interface fp_div_if #(
    parameter int W = 32
);
    logic         start;
    logic         abort;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic [4:0]   fflags;

    modport master (
        output start, abort, a, b,
        input  busy, done, result, fflags
    );

    modport slave (
        input  start, abort, a, b,
        output busy, done, result, fflags
    );
endinterface

// File: rtl/fp_div_unit.sv
// Iterative IEEE-754 binary32 divider (FDIV.S), restoring, one quotient bit per cycle, RNE.
// Subnormal inputs and tiny results are flushed to signed zero.
module fp_div_unit #(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23
) (
    input  logic     clk,
    input  logic     reset,
    fp_div_if.slave  bus
);
    localparam int W   = 1 + EXP_W + FRAC_W;
    localparam int MW  = FRAC_W + 1;
    localparam int RW  = MW + 2;
    localparam int ESW = EXP_W + 2;
    localparam int CW  = $clog2(MW + 1);

    localparam logic [EXP_W-1:0]      EXP_ONES = {EXP_W{1'b1}};
    localparam logic signed [ESW-1:0] EXP_MAX  = ESW'((1 << EXP_W) - 1);
    localparam logic signed [ESW-1:0] EXP_BIAS = ESW'((1 << (EXP_W - 1)) - 1);
    localparam logic signed [ESW-1:0] EXP_ZERO = '0;
    localparam logic [W-1:0]          QNAN     = {1'b0, EXP_ONES, 1'b1, {(FRAC_W-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, UNPACK, DIV, ROUND, DONE} state_t;

    state_t state, next_state;

    logic [W-1:0]            op_a, op_b;
    logic                    sign_q;
    logic signed [ESW-1:0]   exp_q;
    logic [MW-1:0]           div_b;
    logic [RW-1:0]           rem;
    logic [MW:0]             quo;
    logic [CW-1:0]           cnt;
    logic [W-1:0]            result_q;
    logic [4:0]              fflags_q;

    logic [EXP_W-1:0]  ea, eb;
    logic [FRAC_W-1:0] fa, fb;
    logic              a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_snan, b_snan;
    logic              sign_c;
    logic              special;
    logic [W-1:0]      spec_res;
    logic [4:0]        spec_flags;
    logic [MW-1:0]     ma, mb;
    logic              adj;
    logic [RW-1:0]     rem_init;
    logic signed [ESW-1:0] exp_calc;

    logic [MW-1:0]         mant;
    logic                  r_bit, s_bit, inc;
    logic [MW:0]           mant_inc;
    logic [MW-1:0]         mant_f;
    logic signed [ESW-1:0] exp_f;
    logic [W-1:0]          rnd_res;
    logic [4:0]            rnd_flags;
    logic [RW-1:0]         rem_diff;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= next_state;
    end

    // Abort from any busy state returns to IDLE and also suppresses a launch in IDLE.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (bus.start && !bus.abort) next_state = UNPACK;
            UNPACK:  next_state = special ? DONE : DIV;
            DIV:     if (cnt == CW'(MW)) next_state = ROUND;
            ROUND:   next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
        if (bus.abort && state != IDLE) next_state = IDLE;
    end

    always_comb begin
        bus.busy = (state != IDLE);
        bus.done = (state == DONE);
    end

    assign bus.result = result_q;
    assign bus.fflags = fflags_q;

    // Operand classification; exponent zero counts as zero regardless of fraction.
    always_comb begin
        ea     = op_a[W-2 -: EXP_W];
        eb     = op_b[W-2 -: EXP_W];
        fa     = op_a[FRAC_W-1:0];
        fb     = op_b[FRAC_W-1:0];
        a_zero = (ea == '0);
        b_zero = (eb == '0);
        a_inf  = (ea == EXP_ONES) && (fa == '0);
        b_inf  = (eb == EXP_ONES) && (fb == '0);
        a_nan  = (ea == EXP_ONES) && (fa != '0);
        b_nan  = (eb == EXP_ONES) && (fb != '0);
        a_snan = a_nan && !fa[FRAC_W-1];
        b_snan = b_nan && !fb[FRAC_W-1];
        sign_c = op_a[W-1] ^ op_b[W-1];

        special    = 1'b1;
        spec_res   = QNAN;
        spec_flags = 5'b00000;
        if (a_nan || b_nan)
            spec_flags = {a_snan | b_snan, 4'b0000};
        else if ((a_zero && b_zero) || (a_inf && b_inf))
            spec_flags = 5'b10000;
        else if (a_inf)
            spec_res = {sign_c, EXP_ONES, {FRAC_W{1'b0}}};
        else if (b_zero) begin
            spec_res   = {sign_c, EXP_ONES, {FRAC_W{1'b0}}};
            spec_flags = 5'b01000;
        end
        else if (a_zero || b_inf)
            spec_res = {sign_c, {(W-1){1'b0}}};
        else
            special = 1'b0;

        ma       = {1'b1, fa};
        mb       = {1'b1, fb};
        adj      = (ma < mb);
        rem_init = adj ? {1'b0, ma, 1'b0} : {2'b00, ma};
        exp_calc = ESW'({2'b00, ea}) - ESW'({2'b00, eb}) + EXP_BIAS - ESW'(adj);
    end

    // Quotient layout: quo[MW:1] is the significand, quo[0] the round bit.
    always_comb begin
        mant     = quo[MW:1];
        r_bit    = quo[0];
        s_bit    = (rem != '0);
        inc      = r_bit & (s_bit | mant[0]);
        mant_inc = {1'b0, mant} + (MW+1)'(inc);
        if (mant_inc[MW]) begin
            mant_f = {1'b1, {FRAC_W{1'b0}}};
            exp_f  = exp_q + ESW'(1);
        end
        else begin
            mant_f = mant_inc[MW-1:0];
            exp_f  = exp_q;
        end

        if (exp_f >= EXP_MAX) begin
            rnd_res   = {sign_q, EXP_ONES, {FRAC_W{1'b0}}};
            rnd_flags = 5'b00101;
        end
        else if (exp_f <= EXP_ZERO) begin
            rnd_res   = {sign_q, {(W-1){1'b0}}};
            rnd_flags = 5'b00011;
        end
        else begin
            rnd_res   = {sign_q, exp_f[EXP_W-1:0], mant_f[FRAC_W-1:0]};
            rnd_flags = {4'b0000, r_bit | s_bit};
        end

        rem_diff = rem - {2'b00, div_b};
    end

    // Datapath registers; result/fflags only change on the edge entering DONE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_a     <= '0;
            op_b     <= '0;
            sign_q   <= 1'b0;
            exp_q    <= '0;
            div_b    <= '0;
            rem      <= '0;
            quo      <= '0;
            cnt      <= '0;
            result_q <= '0;
            fflags_q <= '0;
        end
        else begin
            case (state)
                IDLE: begin
                    if (bus.start && !bus.abort) begin
                        op_a <= bus.a;
                        op_b <= bus.b;
                    end
                end
                UNPACK: begin
                    if (!bus.abort) begin
                        if (special) begin
                            result_q <= spec_res;
                            fflags_q <= spec_flags;
                        end
                        else begin
                            sign_q <= sign_c;
                            exp_q  <= exp_calc;
                            div_b  <= mb;
                            rem    <= rem_init;
                            quo    <= '0;
                            cnt    <= '0;
                        end
                    end
                end
                DIV: begin
                    if (rem >= {2'b00, div_b}) begin
                        rem <= rem_diff << 1;
                        quo <= {quo[MW-1:0], 1'b1};
                    end
                    else begin
                        rem <= rem << 1;
                        quo <= {quo[MW-1:0], 1'b0};
                    end
                    cnt <= cnt + CW'(1);
                end
                ROUND: begin
                    if (!bus.abort) begin
                        result_q <= rnd_res;
                        fflags_q <= rnd_flags;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fp_div_unit.sv
// Directed self-checking bench for fp_div_unit: results, flags, latency and control corner cases.
module tb_fp_div_unit;
    logic clk;
    logic reset;
    int   total;
    int   bad;
    int   cyc;
    logic saw_done;

    fp_div_if bus ();

    fp_div_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv)
        else begin
            bad++;
            $error("[TB] FAIL %s: got %h want %h", tag, obs, expv);
        end
    endtask

    // Operands are scrambled right after the launch edge so only latched copies can matter.
    task automatic apply_stimulus(input logic [31:0] av, input logic [31:0] bv);
        bus.a     = av;
        bus.b     = bv;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.a     = ~av;
        bus.b     = ~bv;
    endtask

    task automatic wait_done(output int n);
        n = 1;
        while (!bus.done && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic run_div(input string tag, input logic [31:0] av, input logic [31:0] bv,
                           input logic [31:0] eres, input logic [4:0] eflags, input int ecyc);
        int n;
        apply_stimulus(av, bv);
        check_output({tag, ".busy"}, {31'b0, bus.busy}, 32'd1);
        wait_done(n);
        check_output({tag, ".done"}, {31'b0, bus.done}, 32'd1);
        check_output({tag, ".cycle"}, 32'(n), 32'(ecyc));
        check_output({tag, ".result"}, bus.result, eres);
        check_output({tag, ".fflags"}, {27'b0, bus.fflags}, {27'b0, eflags});
        @(posedge clk);
        #1;
        check_output({tag, ".idle"}, {30'b0, bus.busy, bus.done}, 32'd0);
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        reset     = 1'b0;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        #1;
        check_output("rst.busy", {31'b0, bus.busy}, 32'd0);
        check_output("rst.done", {31'b0, bus.done}, 32'd0);
        check_output("rst.result", bus.result, 32'h0);
        check_output("rst.fflags", {27'b0, bus.fflags}, 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] normal and special divides");
        run_div("six_by_two",   32'h40C00000, 32'h40000000, 32'h40400000, 5'h00, 28);
        run_div("one_third",    32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 5'h01, 28);
        run_div("neg_six",      32'hC0C00000, 32'h40000000, 32'hC0400000, 5'h00, 28);
        run_div("one_by_neg1",  32'h3F800000, 32'hBF800000, 32'hBF800000, 5'h00, 28);
        run_div("same_1p5",     32'h3FC00000, 32'h3FC00000, 32'h3F800000, 5'h00, 28);
        run_div("overflow",     32'h7F000000, 32'h00800000, 32'h7F800000, 5'h05, 28);
        run_div("underflow",    32'h00800000, 32'h7F000000, 32'h00000000, 5'h03, 28);
        run_div("div_zero",     32'h3F800000, 32'h00000000, 32'h7F800000, 5'h08, 2);
        run_div("neg_div_zero", 32'hBF800000, 32'h00000000, 32'hFF800000, 5'h08, 2);
        run_div("zero_zero",    32'h00000000, 32'h80000000, 32'h7FC00000, 5'h10, 2);
        run_div("snan",         32'h7F800001, 32'h3F800000, 32'h7FC00000, 5'h10, 2);
        run_div("qnan",         32'h7FC00000, 32'h3F800000, 32'h7FC00000, 5'h00, 2);
        run_div("inf_inf",      32'h7F800000, 32'hFF800000, 32'h7FC00000, 5'h10, 2);
        run_div("ninf_by_two",  32'hFF800000, 32'h40000000, 32'hFF800000, 5'h00, 2);
        run_div("two_by_inf",   32'h40000000, 32'h7F800000, 32'h00000000, 5'h00, 2);
        run_div("subn_a",       32'h00000001, 32'h3F800000, 32'h00000000, 5'h00, 2);
        run_div("subn_b",       32'h3F800000, 32'h00000001, 32'h7F800000, 5'h08, 2);

        $display("[TB] start held during the done cycle");
        apply_stimulus(32'h3F800000, 32'h00000000);
        wait_done(cyc);
        check_output("dstart.cycle", 32'(cyc), 32'd2);
        bus.a     = 32'h40C00000;
        bus.b     = 32'h40000000;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check_output("dstart.busy1", {31'b0, bus.busy}, 32'd0);
        @(posedge clk);
        #1;
        check_output("dstart.busy2", {31'b0, bus.busy}, 32'd0);
        check_output("dstart.result", bus.result, 32'h7F800000);

        $display("[TB] abort together with start in idle");
        bus.start = 1'b1;
        bus.abort = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        check_output("idle_abort.busy", {31'b0, bus.busy}, 32'd0);

        $display("[TB] start while busy is ignored");
        apply_stimulus(32'h40C00000, 32'h40000000);
        cyc = 1;
        while (cyc < 5) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        bus.a     = 32'h3F800000;
        bus.b     = 32'h00000000;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        cyc++;
        while (!bus.done && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check_output("busy_start.cycle", 32'(cyc), 32'd28);
        check_output("busy_start.result", bus.result, 32'h40400000);
        check_output("busy_start.fflags", {27'b0, bus.fflags}, 32'h0);
        @(posedge clk);
        #1;
        run_div("two_thirds", 32'h40000000, 32'h40400000, 32'h3F2AAAAB, 5'h01, 28);

        $display("[TB] abort mid-divide");
        saw_done = 1'b0;
        apply_stimulus(32'h40C00000, 32'h40000000);
        cyc = 1;
        while (cyc < 10) begin
            bus.start = (cyc == 5);
            @(posedge clk);
            #1;
            cyc++;
            saw_done = saw_done | bus.done;
        end
        bus.start = 1'b0;
        bus.abort = 1'b1;
        @(posedge clk);
        #1;
        bus.abort = 1'b0;
        check_output("abort.busy", {31'b0, bus.busy}, 32'd0);
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            saw_done = saw_done | bus.done | bus.busy;
        end
        check_output("abort.no_done", {31'b0, saw_done}, 32'd0);
        check_output("abort.result", bus.result, 32'h3F2AAAAB);
        check_output("abort.fflags", {27'b0, bus.fflags}, 32'h01);

        $display("[TB] reset mid-divide");
        apply_stimulus(32'h3F800000, 32'h40400000);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check_output("mid_rst.busy_before", {31'b0, bus.busy}, 32'd1);
        reset = 1'b0;
        #1;
        check_output("mid_rst.busy", {31'b0, bus.busy}, 32'd0);
        check_output("mid_rst.done", {31'b0, bus.done}, 32'd0);
        check_output("mid_rst.result", bus.result, 32'h0);
        check_output("mid_rst.fflags", {27'b0, bus.fflags}, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_output("mid_rst.idle", {31'b0, bus.busy}, 32'd0);
        run_div("after_reset", 32'h40C00000, 32'h40000000, 32'h40400000, 5'h00, 28);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
